// File: rtl/burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_reader_pkg
// Description : Shared widths and FSM state encoding for the burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_reader_pkg;

    localparam int BR_M = 8;   // word width, equal to the memory cell width
    localparam int BR_K = 11;  // address width
    localparam int BR_L = 8;   // request length width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_reader_if
// Description : Memory port and output stream of the burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface burst_reader_if
    import burst_reader_pkg::*;
#(
    parameter int M = BR_M,
    parameter int K = BR_K
);
    logic [K-1:0]   mem_A;
    logic           mem_WE;
    logic [M-1:0]   mem_WD;
    logic [M-1:0]   mem_RA;
    logic [2*M-1:0] mem_RAdouble;
    logic [M-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output mem_A, mem_WE, mem_WD, out_data, out_valid,
        input  mem_RA, mem_RAdouble, out_ready
    );

    modport slave (
        input  mem_A, mem_WE, mem_WD, out_data, out_valid,
        output mem_RA, mem_RAdouble, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/burst_reader_word_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : word_fifo2
// Description : Two-entry word buffer accepting one or two words per edge.
// Revision    : 1.0 - initial release
// ============================================================================
module word_fifo2 #(
    parameter int M = 8
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         push1_i,
    input  wire logic         push2_i,
    input  wire logic [M-1:0] wd0_i,
    input  wire logic [M-1:0] wd1_i,
    input  wire logic         pop_i,
    output logic      [1:0]   count_o,
    output logic      [M-1:0] head_o
);
    logic [M-1:0] slot0_q, slot0_d;
    logic [M-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;

    // Pop is applied first so a push sees the slot it frees; push2 is only
    // issued against an empty (post-pop) buffer.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (pop_i && (count_q != 2'd0)) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
        if (push2_i) begin
            slot0_d = wd0_i;
            slot1_d = wd1_i;
            count_d = 2'd2;
        end else if (push1_i) begin
            if (count_d == 2'd0) slot0_d = wd0_i;
            else                 slot1_d = wd0_i;
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = slot0_q;
endmodule
`default_nettype wire

// File: rtl/burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : burst_reader
// Description : Sequential read engine using double-word fetches when aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_reader
    import burst_reader_pkg::*;
#(
    parameter int M = BR_M,
    parameter int K = BR_K,
    parameter int L = BR_L
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         start_i,
    input  wire logic [K-1:0] base_i,
    input  wire logic [L-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    burst_reader_if.master    bus
);
    state_t       state_q, state_d;
    logic [K-1:0] addr_q, addr_d;
    logic [L-1:0] rem_q, rem_d;

    logic         w_pop;
    logic         w_push1;
    logic         w_push2;
    logic [1:0]   w_count;
    logic [1:0]   w_count_free;
    logic [M-1:0] w_head;
    logic [M-1:0] w_wd0;

    assign w_pop        = (w_count != 2'd0) && bus.out_ready;
    assign w_count_free = w_count - {1'b0, w_pop};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        w_push1 = 1'b0;
        w_push2 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rem_d = len_i;
                    // Empty request passes through DRAIN (buffer already
                    // empty) to give one busy cycle ahead of the done pulse.
                    if (len_i == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = base_i;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (!addr_q[0] && (rem_q >= L'(2)) && (w_count_free == 2'd0)) begin
                    w_push2 = 1'b1;
                    addr_d  = addr_q + K'(2);
                    rem_d   = rem_q - L'(2);
                end else if ((addr_q[0] || (rem_q == L'(1))) && (w_count_free <= 2'd1)) begin
                    w_push1 = 1'b1;
                    addr_d  = addr_q + K'(1);
                    rem_d   = rem_q - L'(1);
                end
                if (rem_d == '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_count_free == 2'd0) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    assign w_wd0 = w_push2 ? bus.mem_RAdouble[2*M-1:M] : bus.mem_RA;

    word_fifo2 #(.M(M)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push1_i (w_push1),
        .push2_i (w_push2),
        .wd0_i   (w_wd0),
        .wd1_i   (bus.mem_RAdouble[M-1:0]),
        .pop_i   (w_pop),
        .count_o (w_count),
        .head_o  (w_head)
    );

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign bus.mem_A     = addr_q;
    assign bus.mem_WE    = 1'b0;
    assign bus.mem_WD    = '0;
    assign bus.out_valid = (w_count != 2'd0);
    assign bus.out_data  = w_head;
endmodule
`default_nettype wire

// File: tb/tb_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_reader
// Description : Directed table-driven bench for burst_reader; word[i] = i[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_reader;
    import burst_reader_pkg::*;

    typedef struct {
        logic [10:0] base;
        logic [7:0]  len;
        logic [3:0]  rdy;        // out_ready for cycle k is rdy[(k-1)%4]
        int          exp_done;   // cycle (after the accepting edge) holding done
        int          exp_fetch;  // number of mem_A advances after cycle 1
        logic [10:0] exp_a;      // mem_A once the request completes
    } vec_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [10:0] base;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [10:0] a_plus1;
    int          checks;
    int          errors;
    vec_t        vecs[7];
    vec_t        post;

    burst_reader_if bus ();

    burst_reader dut (
        .clock   (clock),
        .reset   (reset),
        .start_i (start),
        .base_i  (base),
        .len_i   (len),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus)
    );

    assign a_plus1          = bus.mem_A + 11'd1;
    assign bus.mem_RA       = bus.mem_A[7:0];
    assign bus.mem_RAdouble = {bus.mem_A[7:0], a_plus1[7:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          nwords;
        int          ndone;
        int          done_cyc;
        int          nchg;
        int          busy_err;
        int          stab_err;
        logic        busy_after;
        logic        prev_hold;
        logic [7:0]  prev_data;
        logic [10:0] prev_a;
        logic [10:0] ea;
        nwords = 0; ndone = 0; done_cyc = -1; nchg = 0;
        busy_err = 0; stab_err = 0; busy_after = 1'b1;
        prev_hold = 1'b0; prev_data = 8'h00; prev_a = 11'h000;

        @(posedge clock); #1;
        start = 1'b1; base = v.base; len = v.len;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            bus.out_ready = v.rdy[(k-1)%4];
            @(negedge clock);
            if (k > 1 && bus.mem_A != prev_a) nchg++;
            prev_a = bus.mem_A;
            if (prev_hold && (!bus.out_valid || bus.out_data != prev_data)) stab_err++;
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                ea = v.base + 11'(nwords);
                chk($sformatf("v%0d_word%0d", id, nwords), 32'(bus.out_data), 32'(ea[7:0]));
                nwords++;
            end
            if (done_cyc > 0 && k == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if (!busy) busy_err++;
            if (done) begin
                ndone++;
                done_cyc = k;
            end
            @(posedge clock); #1;
        end
        chk($sformatf("v%0d_done_cycle", id), 32'(done_cyc), 32'(v.exp_done));
        chk($sformatf("v%0d_done_pulses", id), 32'(ndone), 32'd1);
        chk($sformatf("v%0d_word_count", id), 32'(nwords), 32'(v.len));
        chk($sformatf("v%0d_fetches", id), 32'(nchg), 32'(v.exp_fetch));
        chk($sformatf("v%0d_final_addr", id), 32'(bus.mem_A), 32'(v.exp_a));
        chk($sformatf("v%0d_busy_after_done", id), 32'(busy_after), 32'd0);
        chk($sformatf("v%0d_busy_drops", id), 32'(busy_err), 32'd0);
        chk($sformatf("v%0d_hold_stable", id), 32'(stab_err), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; base = 11'h000; len = 8'h00;
        bus.out_ready = 1'b0;

        vecs[0] = '{11'h010, 8'd8, 4'b1111, 10, 4, 11'h018};
        vecs[1] = '{11'h011, 8'd4, 4'b1111,  6, 3, 11'h015};
        vecs[2] = '{11'h7FF, 8'd3, 4'b1111,  5, 2, 11'h002};
        vecs[3] = '{11'h123, 8'd0, 4'b1111,  2, 0, 11'h002};
        vecs[4] = '{11'h000, 8'd6, 4'b1001, 14, 3, 11'h006};
        vecs[5] = '{11'h7FE, 8'd4, 4'b1111,  6, 2, 11'h002};
        vecs[6] = '{11'h005, 8'd1, 4'b1111,  3, 1, 11'h006};
        post    = '{11'h030, 8'd4, 4'b1111,  6, 2, 11'h034};

        #12;
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_done",      32'(done),          32'd0);
        chk("rst_mem_A",     32'(bus.mem_A),     32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_mem_WE",    32'(bus.mem_WE),    32'd0);
        chk("rst_mem_WD",    32'(bus.mem_WD),    32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Stall the consumer so two words sit in the buffer, then reset mid-cycle.
        @(posedge clock); #1;
        start = 1'b1; base = 11'h040; len = 8'd8; bus.out_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("mid_valid_before_reset", 32'(bus.out_valid), 32'd1);
        chk("mid_data_before_reset",  32'(bus.out_data),  32'h40);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_reset_busy",  32'(busy),          32'd0);
        chk("mid_reset_mem_A", 32'(bus.mem_A),     32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_vec(7, post);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
